mux_sel_ctrl: RTL and testbench

Sequential select controller sitting directly upstream of the 2:1 `mux` primitive and driving its `sel` input. It accepts select-change requests over a valid/ready handshake and enforces a minimum hold time between select changes. It reports completion after a settle window. Optionally, it defers each switch until both data inputs agree, so the mux output cannot glitch during the change.

---
 rtl/mux_sel_ctrl_pkg.sv | 24 ++
 rtl/mux_sel_ctrl_sat_down_cnt.sv | 47 ++++
 rtl/mux_sel_ctrl.sv | 158 +++++++++++++++
 tb/tb_mux_sel_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_sel_ctrl_pkg                                             |
// | Description : Shared types and parameter defaults for the mux select       |
// |               controller (FSM state encoding, counter defaults).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mux_sel_ctrl_pkg;

  // Default configuration of the controller
  localparam int HOLD_CYCLES_DEF   = 4;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int CNT_W_DEF         = 8;

  // Controller state, 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_MATCH  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

endpackage : mux_sel_ctrl_pkg
`default_nettype wire

// File: rtl/mux_sel_ctrl_sat_down_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sat_down_cnt                                                 |
// | Description : Loadable down counter that saturates at zero.                |
// | Ports       : clk      - clock                                             |
// |               rst      - synchronous active-high reset (count -> 0)        |
// |               load_i   - load value_i (priority over decrement)            |
// |               value_i  - load value                                        |
// |               dec_i    - decrement enable (no effect when already 0)       |
// |               zero_o   - count is zero                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sat_down_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule : sat_down_cnt
`default_nettype wire

// File: rtl/mux_sel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mux_sel_ctrl                                                 |
// | Description : Select controller driving the sel input of a 2:1 mux.        |
// |               Accepts select-change requests over valid/ready, enforces a  |
// |               minimum hold time between sel changes and pulses done after  |
// |               a settle window.                                             |
// | Option      : MUX_SEL_MATCH_EN - when defined, each switch is deferred     |
// |               until a_in == b_in so the mux output cannot glitch.          |
// | Ports       : clk, rst    - clock, synchronous active-high reset           |
// |               req_valid   - select-change request present                  |
// |               req_sel     - requested select value (sampled on accept)     |
// |               req_ready   - controller idle, request can be accepted       |
// |               a_in, b_in  - copies of mux data inputs (match gating only)  |
// |               sel         - registered mux select                          |
// |               done        - one-cycle completion pulse per request         |
// |               busy        - request in progress                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mux_sel_ctrl
  import mux_sel_ctrl_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_sel,
  output logic req_ready,
  input  logic a_in,
  input  logic b_in,
  output logic sel,
  output logic done,
  output logic busy
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   tgt_q, tgt_d;
  logic   done_q, done_d;

  logic   switch_now;
  logic   hold_zero;
  logic   settle_zero;
  logic   settle_dec;

  // Hold counter: reloaded on every switch and free-running down to zero,
  // regardless of state, so a request arriving late finds it already expired.
  sat_down_cnt #(.CNT_W(CNT_W)) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (switch_now),
    .value_i (CNT_W'(HOLD_CYCLES)),
    .dec_i   (1'b1),
    .zero_o  (hold_zero)
  );

  // Settle counter: loaded on a switch, counted down only while settling.
  sat_down_cnt #(.CNT_W(CNT_W)) u_settle_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (switch_now),
    .value_i (CNT_W'(SETTLE_CYCLES)),
    .dec_i   (settle_dec),
    .zero_o  (settle_zero)
  );

`ifndef MUX_SEL_MATCH_EN
  // Data copies only matter for match gating.
  logic unused_match_inputs;
  assign unused_match_inputs = a_in ^ b_in;
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tgt_d      = tgt_q;
    done_d     = 1'b0;
    switch_now = 1'b0;
    settle_dec = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_d = req_sel;
          // A request for the current select completes immediately.
          if (req_sel == sel_q) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end

      ST_HOLD: begin
        if (hold_zero) begin
`ifdef MUX_SEL_MATCH_EN
          state_d = ST_MATCH;
`else
          switch_now = 1'b1;
`endif
        end
      end

      ST_MATCH: begin
`ifdef MUX_SEL_MATCH_EN
        // Wait indefinitely for identical data inputs; only rst escapes.
        if (a_in == b_in) begin
          switch_now = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      ST_SETTLE: begin
        if (settle_zero) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          settle_dec = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (switch_now) begin
      sel_d   = tgt_q;
      state_d = ST_SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      tgt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = ~req_ready;
  assign sel       = sel_q;
  assign done      = done_q;

endmodule : mux_sel_ctrl
`default_nettype wire

// File: tb/tb_mux_sel_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mux_sel_ctrl                                              |
// | Description : Self-checking bench for mux_sel_ctrl: directed vector table, |
// |               hand-written corner sequences and random stimulus against an |
// |               edge-arithmetic reference model.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mux_sel_ctrl;

  localparam int H = 8;
  localparam int S = 2;
`ifdef MUX_SEL_MATCH_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif

  logic clk = 1'b0;
  logic rst, req_valid, req_sel, a_in, b_in;
  logic req_ready, sel, done, busy;

  mux_sel_ctrl #(
    .HOLD_CYCLES   (H),
    .SETTLE_CYCLES (S),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .sel       (sel),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: tracks edges at which things must happen.
  bit m_sel = 0, m_done = 0, m_pend = 0, m_swd = 0, m_tgt = 0;
  int m_last = -1000;  // edge of last sel change
  int m_em = 0;        // earliest edge the hold allows leaving HOLD
  int m_done_edge = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_sel = 0; m_done = 0; m_pend = 0; m_swd = 0; m_last = -1000;
    end else begin
      m_done = 0;
      if (!m_pend) begin
        if (req_valid) begin
          if (req_sel == m_sel) begin
            m_done = 1;
          end else begin
            m_pend = 1; m_swd = 0; m_tgt = req_sel;
            m_em = (cyc + 1 > m_last + H + 1) ? cyc + 1 : m_last + H + 1;
          end
        end
      end else if (!m_swd) begin
        if ((M == 1) ? (cyc > m_em && a_in == b_in) : (cyc == m_em)) begin
          m_sel = m_tgt; m_last = cyc; m_swd = 1; m_done_edge = cyc + S + 1;
        end
      end else if (cyc == m_done_edge) begin
        m_done = 1; m_pend = 0; m_swd = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input logic a, input logic b);
    rst = r; req_valid = v; req_sel = s; a_in = a; b_in = b;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("sel", {31'd0, sel}, {31'd0, m_sel});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("busy", {31'd0, busy}, {31'd0, m_pend});
    chk("req_ready", {31'd0, req_ready}, {31'd0, !m_pend});
  endtask

  typedef struct {
    logic r, v, s, a, b;
    logic e_sel, e_done, e_busy;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic r, v, s, a, b, e_sel, e_done, e_busy);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.a = a; t.b = b;
    t.e_sel = e_sel; t.e_done = e_done; t.e_busy = e_busy;
    tbl.push_back(t);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, sw_edge, dn_edge, exp_sw;
    bit seen;

    // ---------------- directed table: reset, single switch, same-select ----
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1);                      // accept at E0
    for (int k = 1; k <= M + S + 2; k++)
      add(0, 0, 0, 0, 0, k >= 1 + M, k == M + S + 2, k < M + S + 2);
    add(0, 1, 1, 0, 0, 1, 1, 0);                      // same-select request
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 1, 1, 0, 1, 1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].a, tbl[i].b);
      chk("tbl_sel",  {31'd0, sel},  {31'd0, tbl[i].e_sel});
      chk("tbl_done", {31'd0, done}, {31'd0, tbl[i].e_done});
      chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].e_busy});
    end

    // ---------------- hold enforcement -------------------------------------
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    e0 = cyc;
    for (int k = 1; k <= M + S + 2; k++) step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);                              // switch-back accepted
    chk("hold_accept_edge", cyc - e0, M + S + 3);
    exp_sw = (1 + M) + H + 1 + M;
    seen = 0; sw_edge = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 0, 0, 0, 0);
      if (sel == 1'b0) begin seen = 1; sw_edge = cyc - e0; end
    end
    chk("hold_switch_edge", sw_edge, exp_sw);
    seen = 0; dn_edge = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0, 0);
      if (done) begin seen = 1; dn_edge = cyc - e0; end
    end
    chk("hold_done_edge", dn_edge, exp_sw + S + 1);

    // ---------------- reset in the middle of SETTLE ------------------------
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(0, 0, 0, 0, 0);
      if (sel) seen = 1;
    end
    chk("rst_mid_switch_seen", {31'd0, seen}, 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_mid_sel",   {31'd0, sel},       0);
    chk("rst_mid_done",  {31'd0, done},      0);
    chk("rst_mid_ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < S + 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("rst_mid_no_done", {31'd0, done}, 0);
    end

`ifdef MUX_SEL_MATCH_EN
    // ---------------- match gating -----------------------------------------
    step(1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 0);
      chk("match_stall_sel",  {31'd0, sel},  0);
      chk("match_stall_busy", {31'd0, busy}, 1);
    end
    step(0, 0, 0, 1, 1);
    chk("match_switch_sel", {31'd0, sel}, 1);
    for (int i = 0; i < S; i++) begin
      step(0, 0, 0, 1, 0);
      chk("match_settle_no_done", {31'd0, done}, 0);
    end
    step(0, 0, 0, 1, 0);
    chk("match_done", {31'd0, done}, 1);
`endif

    // ---------------- random stimulus against the model --------------------
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic r, v, s, a, b;
      r = ($urandom_range(0, 63) == 0);
      v = $urandom_range(0, 1);
      s = $urandom_range(0, 1);
      a = $urandom_range(0, 1);
      b = ($urandom_range(0, 3) == 0) ? a : 1'($urandom_range(0, 1));
      step(r, v, s, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux_sel_ctrl
`default_nettype wire
